// File: rtl/ub_read_streamer_pkg.sv
// Shared definitions for the unified-buffer read path: geometry defaults,
// streamer FSM encoding and the output FIFO level arithmetic.
package ub_read_streamer_pkg;

    localparam int unsigned UB_RAM_WIDTH  = 128;
    localparam int unsigned UB_ADDR_WIDTH = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    // Level of a 2-entry FIFO after one cycle of push/pop; push+pop is neutral.
    function automatic logic [1:0] fifo_level_next(input logic [1:0] level,
                                                   input logic       push,
                                                   input logic       pop);
        logic [1:0] nxt;
        nxt = level;
        if (push && !pop) begin
            nxt = level + 2'd1;
        end else if (!push && pop) begin
            nxt = level - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ub_read_streamer_skid_fifo.sv
// Two-entry fall-through FIFO: an incoming row is visible on the output in the
// same cycle it arrives when the FIFO is empty, and is stored if not taken.
module ub_skid_fifo
    import ub_read_streamer_pkg::*;
#(
    parameter int unsigned WIDTH = UB_RAM_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       level_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       level_q;
    logic             empty;
    logic             pop_fire;
    logic             bypass;
    logic             wr_en;
    logic             rd_adv;

    // Output selection (stored head, else incoming row) and storage controls.
    always_comb begin
        empty    = (level_q == 2'd0);
        valid_o  = !empty || push_i;
        data_o   = '0;
        if (!empty) begin
            data_o = mem_q[rd_ptr_q];
        end else if (push_i) begin
            data_o = push_data_i;
        end
        pop_fire = pop_i && valid_o;
        bypass   = empty && push_i && pop_fire;
        wr_en    = push_i && !bypass;
        rd_adv   = pop_fire && !empty;
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            level_q  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (rd_adv) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            level_q <= fifo_level_next(level_q, push_i, pop_fire);
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/ub_read_streamer.sv
// Streams cmd_len consecutive unified-buffer rows from cmd_addr to a
// valid/ready sink, limiting reads so the 2-entry output FIFO never overflows.
module ub_read_streamer
    import ub_read_streamer_pkg::*;
#(
    parameter int unsigned RAM_WIDTH  = UB_RAM_WIDTH,
    parameter int unsigned ADDR_WIDTH = UB_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic                  ub_enb,
    output logic [ADDR_WIDTH-1:0] ub_addrb,
    input  logic [RAM_WIDTH-1:0]  ub_doutb,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [RAM_WIDTH-1:0]  m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned LEN_W  = ADDR_WIDTH + 1;
    localparam int unsigned FIFO_W = RAM_WIDTH + 1;

    logic [1:0]            state_q,     state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;
    logic                  ub_enb_q,    ub_enb_d;
    logic [ADDR_WIDTH-1:0] ub_addrb_q,  ub_addrb_d;
    logic                  rd_last_q,   rd_last_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q,   rd_addr_d;
    logic [LEN_W-1:0]      rd_left_q,   rd_left_d;
    logic                  ret_valid_q;
    logic                  ret_last_q;

    logic                  fifo_valid;
    logic [FIFO_W-1:0]     fifo_data;
    logic [1:0]            fifo_level;
    logic [1:0]            level_next;
    logic                  beat_fire;
    logic                  room;

    ub_skid_fifo #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (ret_valid_q),
        .push_data_i ({ret_last_q, ub_doutb}),
        .pop_i       (m_ready),
        .valid_o     (fifo_valid),
        .data_o      (fifo_data),
        .level_o     (fifo_level)
    );

    assign m_valid   = fifo_valid;
    assign m_data    = fifo_data[RAM_WIDTH-1:0];
    assign m_last    = fifo_data[RAM_WIDTH];
    assign beat_fire = fifo_valid && m_ready;

    // A read may issue next cycle only if stored plus outstanding rows stay below two.
    always_comb begin
        level_next = fifo_level_next(fifo_level, ret_valid_q, beat_fire);
        room       = (level_next == 2'd0) || ((level_next == 2'd1) && !ub_enb_q);
    end

    // Next-state and read-issue decisions.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ub_enb_d    = 1'b0;
        ub_addrb_d  = ub_addrb_q;
        rd_last_d   = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_left_d   = rd_left_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = ST_STREAM;
                        cmd_ready_d = 1'b0;
                        busy_d      = 1'b1;
                        ub_enb_d    = 1'b1;
                        ub_addrb_d  = cmd_addr;
                        rd_last_d   = (cmd_len == LEN_W'(1));
                        rd_addr_d   = cmd_addr + ADDR_WIDTH'(1);
                        rd_left_d   = cmd_len - LEN_W'(1);
                    end
                end
            end
            ST_STREAM: begin
                if (rd_left_q == '0) begin
                    state_d = ST_DRAIN;
                end else if (room) begin
                    ub_enb_d   = 1'b1;
                    ub_addrb_d = rd_addr_q;
                    rd_last_d  = (rd_left_q == LEN_W'(1));
                    rd_addr_d  = rd_addr_q + ADDR_WIDTH'(1);
                    rd_left_d  = rd_left_q - LEN_W'(1);
                    if (rd_left_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (beat_fire && m_last) begin
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // Control and read-pipeline registers; reset discards any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ub_enb_q    <= 1'b0;
            ub_addrb_q  <= '0;
            rd_last_q   <= 1'b0;
            rd_addr_q   <= '0;
            rd_left_q   <= '0;
            ret_valid_q <= 1'b0;
            ret_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ub_enb_q    <= ub_enb_d;
            ub_addrb_q  <= ub_addrb_d;
            rd_last_q   <= rd_last_d;
            rd_addr_q   <= rd_addr_d;
            rd_left_q   <= rd_left_d;
            ret_valid_q <= ub_enb_q;
            ret_last_q  <= rd_last_q;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ub_enb    = ub_enb_q;
    assign ub_addrb  = ub_addrb_q;

endmodule

// File: doc/ub_read_streamer.md
UB_READ_STREAMER -- requirements
Module: ub_read_streamer

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 128, data width of one unified-buffer row.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, unified-buffer address width (256 rows).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port cmd_valid, input, 1, read command offered.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid and cmd_ready are both high.
REQ-007 SHALL have port cmd_addr, input, ADDR_WIDTH, first row to read.
REQ-008 SHALL have port cmd_len, input, ADDR_WIDTH+1, number of rows to read, 0..256.
REQ-009 SHALL have port ub_enb, output, 1, buffer read enable.
REQ-010 SHALL have port ub_addrb, output, ADDR_WIDTH, buffer read address.
REQ-011 SHALL have port ub_doutb, input, RAM_WIDTH, buffer read data, valid exactly one cycle after ub_enb (low-latency mode).
REQ-012 SHALL have port m_valid, output, 1, output beat valid.
REQ-013 SHALL have port m_ready, input, 1, sink accepts beat.
REQ-014 SHALL have port m_data, output, RAM_WIDTH, row data.
REQ-015 SHALL have port m_last, output, 1, marks the final beat of a command.
REQ-016 SHALL have port busy, output, 1, high from command acceptance until the done pulse.
REQ-017 SHALL have port done, output, 1, one-cycle pulse when a command completes.

Function
REQ-018 SHALL implement FSM states IDLE, STREAM, DRAIN; IDLE->STREAM on accepted command with cmd_len>0; STREAM->DRAIN when the last read is issued; DRAIN->IDLE when the last beat is accepted by the sink.
REQ-019 SHALL drive cmd_ready high only in IDLE; commands offered in any other state are not accepted.
REQ-020 SHALL, for cmd_len=0, remain in IDLE, issue no reads or beats, and pulse done the cycle after acceptance.
REQ-021 SHALL issue reads at consecutive addresses cmd_addr, cmd_addr+1, ... modulo 2^ADDR_WIDTH (255 wraps to 0).
REQ-022 SHALL buffer returned rows in a 2-entry output FIFO; a read SHALL be issued only when FIFO occupancy plus in-flight reads is less than 2, so no row is ever dropped.
REQ-023 SHALL achieve first m_valid two cycles after acceptance (accept at T, ub_enb at T+1, m_valid at T+2) with m_ready held high.
REQ-024 SHALL sustain one beat per cycle while m_ready is high.
REQ-025 SHALL hold m_data and m_last stable while m_valid is high and m_ready is low.
REQ-026 SHALL assert m_last only on beat number cmd_len.
REQ-027 SHALL pulse done in the cycle after the m_last beat is accepted; busy SHALL fall in that same cycle.
REQ-028 SHALL drive ub_enb low whenever no read is being issued; ub_addrb value is don't-care when ub_enb is low.
REQ-029 SHALL handle simultaneous FIFO push (returned row) and pop (sink accept) in one cycle without change of occupancy.

Reset
REQ-030 SHALL, while rst_n is low, force the FSM to IDLE and drive cmd_ready=1, ub_enb=0, m_valid=0, m_last=0, busy=0, done=0, m_data=0, with FIFO empty.
REQ-031 SHALL, on reset mid-command, discard in-flight reads and FIFO contents; no beat and no done pulse follow reset release.

Structure
REQ-032 SHALL place the FSM state encoding and the RAM_WIDTH/ADDR_WIDTH defaults in a shared package used with the unified buffer.
REQ-033 SHALL implement the 2-entry output FIFO as sub-module ub_skid_fifo.

Verification
REQ-034 SHALL verify: reset, then cmd_addr=0x10, cmd_len=4, m_ready=1 -> rows 0x10..0x13 on cycles T+2..T+5, m_last on row 0x13, done at T+6.
REQ-035 SHALL verify: cmd_addr=0xFE, cmd_len=4 -> reads at 0xFE, 0xFF, 0x00, 0x01 in order.
REQ-036 SHALL verify: cmd_len=8 with m_ready toggling 1,0,0,1 repeating -> all 8 rows delivered in order, none duplicated or lost, ub_enb never high when FIFO+in-flight=2.
REQ-037 SHALL verify: cmd_len=0 -> no ub_enb, no m_valid, done pulses at T+1.
REQ-038 SHALL verify: rst_n low after 3 of 10 beats -> outputs at reset values; a new cmd_len=2 after release yields exactly 2 beats.
REQ-039 SHALL verify: cmd_len=256 from cmd_addr=0 -> 256 beats covering all rows, m_last only on beat 256.
